// File: rtl/skl_32_cskip_8_sub_pipe.sv
// 32-bit subtractor, four 8-bit carry-skip blocks, one block per pipeline stage.
// Valid/ready handshake with bubble-collapsing stall chain; stage k finishes block k.
module skl_32_cskip_8_sub_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] d,
    output logic        bout,
    output logic        eq,
    output logic        out_valid,
    input  logic        out_ready
);

    // One 8-bit block of a + ~b + cin; the block carry bypasses the ripple
    // whenever every bit propagates.
    function automatic logic [8:0] blk_sub(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       cin
    );
        logic [7:0] nb;
        logic [7:0] p;
        logic [7:0] g;
        logic [7:0] s;
        logic [8:0] c;
        logic       grp_p;
        nb   = ~b;
        p    = a ^ nb;
        g    = a & nb;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s     = p ^ c[7:0];
        grp_p = &p;
        blk_sub = {(grp_p ? cin : c[8]), s};
    endfunction

    logic        r_v0;
    logic        r_v1;
    logic        r_v2;
    logic        r_v3;

    logic [7:0]  r_s0_d;
    logic        r_s0_c;
    logic [23:0] r_s0_x1;
    logic [23:0] r_s0_x2;

    logic [15:0] r_s1_d;
    logic        r_s1_c;
    logic [15:0] r_s1_x1;
    logic [15:0] r_s1_x2;

    logic [23:0] r_s2_d;
    logic        r_s2_c;
    logic [7:0]  r_s2_x1;
    logic [7:0]  r_s2_x2;

    logic [31:0] r_s3_d;
    logic        r_s3_bout;

    logic [8:0]  w_b0;
    logic [8:0]  w_b1;
    logic [8:0]  w_b2;
    logic [8:0]  w_b3;

    logic        w_adv0;
    logic        w_adv1;
    logic        w_adv2;
    logic        w_adv3;
    logic        w_free0;
    logic        w_free1;
    logic        w_free2;
    logic        w_free3;
    logic        w_acc;

    assign w_b0 = blk_sub(x1[7:0], x2[7:0], ~bin);
    assign w_b1 = blk_sub(r_s0_x1[7:0], r_s0_x2[7:0], r_s0_c);
    assign w_b2 = blk_sub(r_s1_x1[7:0], r_s1_x2[7:0], r_s1_c);
    assign w_b3 = blk_sub(r_s2_x1, r_s2_x2, r_s2_c);

    // Ready ripples back from the output so bubbles collapse in one cycle.
    assign w_adv3  = r_v3 & out_ready;
    assign w_free3 = ~r_v3 | out_ready;
    assign w_adv2  = r_v2 & w_free3;
    assign w_free2 = ~r_v2 | w_adv2;
    assign w_adv1  = r_v1 & w_free2;
    assign w_free1 = ~r_v1 | w_adv1;
    assign w_adv0  = r_v0 & w_free1;
    assign w_free0 = ~r_v0 | w_adv0;

    assign in_ready = w_free0 & ~rst;
    assign w_acc    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_s0_d    <= '0;
            r_s0_c    <= 1'b0;
            r_s0_x1   <= '0;
            r_s0_x2   <= '0;
            r_s1_d    <= '0;
            r_s1_c    <= 1'b0;
            r_s1_x1   <= '0;
            r_s1_x2   <= '0;
            r_s2_d    <= '0;
            r_s2_c    <= 1'b0;
            r_s2_x1   <= '0;
            r_s2_x2   <= '0;
            r_s3_d    <= '0;
            r_s3_bout <= 1'b0;
        end else begin
            r_v0 <= w_acc | (r_v0 & ~w_adv0);
            r_v1 <= w_adv0 | (r_v1 & ~w_adv1);
            r_v2 <= w_adv1 | (r_v2 & ~w_adv2);
            r_v3 <= w_adv2 | (r_v3 & ~w_adv3);
            // Data only loads on a transfer, so an idle stage keeps its last value.
            if (w_acc) begin
                r_s0_d  <= w_b0[7:0];
                r_s0_c  <= w_b0[8];
                r_s0_x1 <= x1[31:8];
                r_s0_x2 <= x2[31:8];
            end
            if (w_adv0) begin
                r_s1_d  <= {w_b1[7:0], r_s0_d};
                r_s1_c  <= w_b1[8];
                r_s1_x1 <= r_s0_x1[23:8];
                r_s1_x2 <= r_s0_x2[23:8];
            end
            if (w_adv1) begin
                r_s2_d  <= {w_b2[7:0], r_s1_d};
                r_s2_c  <= w_b2[8];
                r_s2_x1 <= r_s1_x1[15:8];
                r_s2_x2 <= r_s1_x2[15:8];
            end
            if (w_adv2) begin
                r_s3_d    <= {w_b3[7:0], r_s2_d};
                r_s3_bout <= ~w_b3[8];
            end
        end
    end

    assign out_valid = r_v3;
    assign d         = r_s3_d;
    assign bout      = r_s3_bout;
    assign eq        = r_v3 & ~r_s3_bout & (r_s3_d == 32'd0);

endmodule

// File: tb/tb_skl_32_cskip_8_sub_pipe.sv
// Bench for skl_32_cskip_8_sub_pipe: directed vectors, backpressure, bubbles,
// reset mid-stream; results checked in order against an arithmetic model.
module tb_skl_32_cskip_8_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d;
    logic        bout;
    logic        eq;
    logic        out_valid;
    logic        out_ready;

    skl_32_cskip_8_sub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .x1        (x1),
        .x2        (x2),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .eq        (eq),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        eq;
    } res_t;

    res_t        expq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] d_prev;
    logic        bout_prev;

    function automatic res_t ref_sub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        c
    );
        res_t        r;
        logic [32:0] t;
        t      = {1'b0, a} - {1'b0, b} - {32'd0, c};
        r.d    = t[31:0];
        r.bout = t[32];
        r.eq   = (t == 33'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then advance past the edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_d", {32'd0, d}, {32'd0, d_prev});
                chk("stall_bout", {63'd0, bout}, {63'd0, bout_prev});
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("d", {32'd0, d}, {32'd0, e.d});
                    chk("bout", {63'd0, bout}, {63'd0, e.bout});
                    chk("eq", {63'd0, eq}, {63'd0, e.eq});
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_sub(x1, x2, bin));
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            d_prev     = d;
            bout_prev  = bout;
        end
        @(posedge clk);
        if (rst) expq.delete();
        #1;
    endtask

    task automatic rand_ops();
        x1  = $urandom;
        x2  = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
        bin = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && expq.size() != 0; i++) step();
        chk("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    logic [31:0] tv_x1 [4] = '{32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] tv_x2 [4] = '{32'h0000_0001, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0000};
    logic        tv_bi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] tv_d  [4] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic        tv_bo [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        tv_eq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int a0;
        int o0;
        int prev;
        rst       = 1'b1;
        x1        = '0;
        x2        = '0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_d", {32'd0, d}, 64'd0);
        chk("reset_bout", {63'd0, bout}, 64'd0);
        chk("reset_eq", {63'd0, eq}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic subtraction and four-edge latency
        x1       = 32'd5;
        x2       = 32'd3;
        bin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("latency_valid", {63'd0, out_valid}, {63'd0, (i == 3)});
            if (i < 3) step();
        end
        chk("basic_d", {32'd0, d}, 64'd2);
        chk("basic_bout", {63'd0, bout}, 64'd0);
        chk("basic_eq", {63'd0, eq}, 64'd0);
        step();

        // Directed borrow / skip-path vectors
        for (int k = 0; k < 4; k++) begin
            x1       = tv_x1[k];
            x2       = tv_x2[k];
            bin      = tv_bi[k];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) step();
            chk("vec_valid", {63'd0, out_valid}, 64'd1);
            chk("vec_d", {32'd0, d}, {32'd0, tv_d[k]});
            chk("vec_bout", {63'd0, bout}, {63'd0, tv_bo[k]});
            chk("vec_eq", {63'd0, eq}, {63'd0, tv_eq[k]});
            step();
        end
        drain(10);

        // Backpressure: six offers, four fit
        out_ready = 1'b0;
        a0 = n_acc;
        o0 = n_out;
        rand_ops();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prev = n_acc;
            step();
            if (n_acc != prev) rand_ops();
        end
        chk("bp_accepted", 64'(n_acc - a0), 64'd4);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (n_acc - a0) < 6; i++) begin
            prev = n_acc;
            step();
            if (n_acc != prev) rand_ops();
        end
        drain(20);
        chk("bp_results", 64'(n_out - o0), 64'd6);

        // Full-rate streaming
        o0 = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            step();
        end
        drain(10);
        chk("stream_results", 64'(n_out - o0), 64'd40);

        // Bubbles with random backpressure
        rand_ops();
        for (int i = 0; i < 300; i++) begin
            prev      = n_acc;
            in_valid  = (i % 2 == 0);
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (n_acc != prev) rand_ops();
        end
        drain(30);
        chk("bubble_balance", 64'(n_acc - n_out), 64'd0);

        // Reset with three operands in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        in_valid = 1'b0;
        chk("rst_inflight", 64'(expq.size()), 64'd3);
        o0  = n_out;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_d", {32'd0, d}, 64'd0);
        chk("rst_bout", {63'd0, bout}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("rst_no_results", 64'(n_out - o0), 64'd0);
        chk("rst_out_quiet", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
